// File: rtl/hif_pkg.sv
// hif_pkg: shared types and constants for the host IO cycle arbiter.
//   hif_state_e     : arbiter FSM states
//   TGT_*           : one-hot target codes, bit order {mem, gra, crt, attr}
//   PORT_*          : even (index) address of each decoded VGA register pair
package hif_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } hif_state_e;

  localparam logic [3:0] TGT_NONE = 4'b0000;
  localparam logic [3:0] TGT_ATTR = 4'b0001;
  localparam logic [3:0] TGT_CRT  = 4'b0010;
  localparam logic [3:0] TGT_GRA  = 4'b0100;
  localparam logic [3:0] TGT_MEM  = 4'b1000;

  localparam logic [15:0] PORT_ATTR      = 16'h03C0;
  localparam logic [15:0] PORT_MEM       = 16'h03C4;
  localparam logic [15:0] PORT_GRA       = 16'h03CE;
  localparam logic [15:0] PORT_CRT_MONO  = 16'h03B4;
  localparam logic [15:0] PORT_CRT_COLOR = 16'h03D4;

endpackage

// File: rtl/hif_io_arb_if.sv
// hif_io_arb_if: host request, target handshake and arbiter status signals.
//   master : host / target side (drives request fields and target ready_n)
//   slave  : arbiter side (drives busy, target select, strobe, done, err)
interface hif_io_arb_if;

  logic        h_io_req;
  logic        h_io_rd;
  logic        h_io_16;
  logic [15:0] h_io_addr;
  logic        c_misc_io_sel;
  logic        a_ready_n;
  logic        c_ready_n;
  logic        g_ready_n;
  logic        m_ready_n;

  logic        h_io_busy;
  logic [3:0]  io_tgt_sel;
  logic        io_strobe;
  logic        io_rd;
  logic [15:0] io_byte_addr;
  logic        io_hi_byte;
  logic        h_io_done;
  logic        h_io_err;

  modport master (
    output h_io_req, h_io_rd, h_io_16, h_io_addr, c_misc_io_sel,
    output a_ready_n, c_ready_n, g_ready_n, m_ready_n,
    input  h_io_busy, io_tgt_sel, io_strobe, io_rd, io_byte_addr, io_hi_byte,
    input  h_io_done, h_io_err
  );

  modport slave (
    input  h_io_req, h_io_rd, h_io_16, h_io_addr, c_misc_io_sel,
    input  a_ready_n, c_ready_n, g_ready_n, m_ready_n,
    output h_io_busy, io_tgt_sel, io_strobe, io_rd, io_byte_addr, io_hi_byte,
    output h_io_done, h_io_err
  );

endinterface

// File: rtl/hif_io_dec.sv
// hif_io_dec: combinational VGA IO port decoder.
//   addr_i        : byte address of the current sub-cycle
//   misc_io_sel_i : 1 = CRTC at 3Dx, 0 = CRTC at 3Bx
//   tgt_o         : one-hot target {mem, gra, crt, attr}, zero when unmapped
//   hit_o         : some target decoded
module hif_io_dec
  import hif_pkg::*;
(
  input  logic [15:0] addr_i,
  input  logic        misc_io_sel_i,
  output logic [3:0]  tgt_o,
  output logic        hit_o
);

  // Each target owns an index/data pair, so bit 0 is a don't-care.
  always_comb begin
    tgt_o = TGT_NONE;
    if (addr_i[15:1] == PORT_ATTR[15:1]) begin
      tgt_o = TGT_ATTR;
    end else if (addr_i[15:1] == PORT_GRA[15:1]) begin
      tgt_o = TGT_GRA;
    end else if (addr_i[15:1] == PORT_MEM[15:1]) begin
      tgt_o = TGT_MEM;
    end else if (misc_io_sel_i && (addr_i[15:1] == PORT_CRT_COLOR[15:1])) begin
      tgt_o = TGT_CRT;
    end else if (!misc_io_sel_i && (addr_i[15:1] == PORT_CRT_MONO[15:1])) begin
      tgt_o = TGT_CRT;
    end
    hit_o = |tgt_o;
  end

endmodule

// File: rtl/hif_io_arb.sv
// hif_io_arb: host IO cycle arbiter/sequencer.
// Latches one host IO request, decodes it to a VGA target, strobes the target,
// waits for its ready_n and splits 16-bit cycles into low then high byte.
//   h_hclk  : clock, rising edge
//   h_reset : asynchronous active-high reset
//   bus     : hif_io_arb_if.slave (request in, target handshake, status out)
// Optional build macro HIF_IO_TIMEOUT_EN adds a WAIT-state watchdog that aborts
// after TIMEOUT_CYC cycles and flags h_io_err with h_io_done.
module hif_io_arb
  import hif_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic         h_hclk,
  input logic         h_reset,
  hif_io_arb_if.slave bus
);

  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 1024)) begin : g_bad_timeout
    $error("hif_io_arb: TIMEOUT_CYC must lie in 2..1024");
  end

  hif_state_e  state_q, state_d;
  logic        rd_q, rd_d;
  logic        is16_q, is16_d;
  logic [15:0] addr_q, addr_d;
  logic        hi_q, hi_d;
  logic [3:0]  tgt_q, tgt_d;

  logic [3:0]  dec_tgt;
  logic        dec_hit;
  logic        sel_ready;

`ifdef HIF_IO_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Decoder always sees the current byte address, so the high byte re-decodes.
  hif_io_dec u_dec (
    .addr_i        (addr_q),
    .misc_io_sel_i (bus.c_misc_io_sel),
    .tgt_o         (dec_tgt),
    .hit_o         (dec_hit)
  );

  // Only the selected target's ready is looked at; the others are masked off.
  assign sel_ready = |(tgt_q & ~{bus.m_ready_n, bus.g_ready_n, bus.c_ready_n, bus.a_ready_n});

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    is16_d  = is16_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    tgt_d   = tgt_q;
`ifdef HIF_IO_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.h_io_req) begin
          rd_d    = bus.h_io_rd;
          is16_d  = bus.h_io_16;
          addr_d  = bus.h_io_addr;
          hi_d    = 1'b0;
          state_d = StIssue;
`ifdef HIF_IO_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      StIssue: begin
        if (dec_hit) begin
          tgt_d   = dec_tgt;
          state_d = StWait;
`ifdef HIF_IO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          // Unmapped byte: no strobe, and any remaining half is skipped too.
          state_d = StDone;
        end
      end
      StWait: begin
        if (sel_ready) begin
          if (is16_q && !hi_q) begin
            hi_d    = 1'b1;
            addr_d  = addr_q + 16'd1;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
`ifdef HIF_IO_TIMEOUT_EN
        else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge h_hclk or posedge h_reset) begin
    if (h_reset) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      is16_q  <= 1'b0;
      addr_q  <= 16'h0000;
      hi_q    <= 1'b0;
      tgt_q   <= TGT_NONE;
`ifdef HIF_IO_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      is16_q  <= is16_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      tgt_q   <= tgt_d;
`ifdef HIF_IO_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    bus.io_tgt_sel = TGT_NONE;
    if (state_q == StIssue) begin
      bus.io_tgt_sel = dec_tgt;
    end else if (state_q == StWait) begin
      bus.io_tgt_sel = tgt_q;
    end
    bus.io_strobe    = (state_q == StIssue) && dec_hit;
    bus.io_rd        = rd_q;
    bus.io_byte_addr = addr_q;
    bus.io_hi_byte   = hi_q;
    bus.h_io_busy    = (state_q != StIdle);
    bus.h_io_done    = (state_q == StDone);
`ifdef HIF_IO_TIMEOUT_EN
    bus.h_io_err     = (state_q == StDone) && err_q;
`else
    bus.h_io_err     = 1'b0;
`endif
  end

endmodule
